// File: rtl/cpu_defs_pkg.sv
// Shared CPU-side bus types: physical address, burst length, and arbiter state/owner encodings.
package cpu_defs;

  typedef logic [31:0] phys_t;

  localparam int MEM_LEN_W = 4;
  typedef logic [MEM_LEN_W-1:0] mem_len_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } arb_state_t;

  typedef enum logic [1:0] {
    IC = 2'd0,
    DC = 2'd1,
    WB = 2'd2
  } arb_owner_t;

  // Read-side one-hot for a burst owner; the writeback owner maps to no read lane.
  function automatic logic [1:0] owner_onehot(input arb_owner_t owner);
    case (owner)
      IC:      owner_onehot = 2'b01;
      DC:      owner_onehot = 2'b10;
      default: owner_onehot = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding memory bus arbiter: icache/dcache refills and dcache writeback
// share one burst memory port; writeback wins, reads alternate round-robin.
module mem_bus_arbiter
  import cpu_defs::*;
#(
  parameter int LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             rd_req,
  input  phys_t [1:0]            rd_addr,
  input  logic [1:0][LEN_W-1:0]  rd_len,
  output logic [1:0]             rd_gnt,
  output logic [1:0]             rd_valid,
  output logic [31:0]            rd_data,
  output logic                   rd_last,
  input  logic                   wr_req,
  input  phys_t                  wr_addr,
  input  logic [LEN_W-1:0]       wr_len,
  output logic                   wr_gnt,
  input  logic [31:0]            wr_data,
  output logic                   wr_ready,
  output logic                   wr_done,
  output logic                   mem_req,
  output logic                   mem_we,
  output phys_t                  mem_addr,
  output logic [LEN_W-1:0]       mem_len,
  input  logic                   mem_ack,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata,
  output logic                   mem_wvalid,
  output logic [31:0]            mem_wdata,
  output logic                   mem_wlast,
  input  logic                   mem_wready,
  input  logic                   mem_bvalid
);

  arb_state_t       state;
  arb_owner_t       owner;
  logic             last_rd_dc;
  logic [LEN_W-1:0] cnt;
  phys_t            addr_q;
  logic [LEN_W-1:0] len_q;

  logic             rd_pick_dc;
  logic             arb_fire;
  logic             in_addr;
  logic             cnt_zero;
  logic [1:0]       owner_oh;

  // Read tie goes to whichever cache was not served last.
  always_comb begin
    rd_pick_dc = 1'b0;
    if (rd_req == 2'b10)
      rd_pick_dc = 1'b1;
    else if (rd_req == 2'b11)
      rd_pick_dc = ~last_rd_dc;
  end

  assign arb_fire = (state == IDLE) && (wr_req || (rd_req != 2'b00));
  assign in_addr  = (state == RD_ADDR) || (state == WR_ADDR);
  assign cnt_zero = (cnt == '0);
  assign owner_oh = owner_onehot(owner);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= IC;
      last_rd_dc <= 1'b1;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_req) begin
            state <= WR_ADDR;
            owner <= WB;
          end else if (rd_req != 2'b00) begin
            state <= RD_ADDR;
            owner <= rd_pick_dc ? DC : IC;
          end
        end
        RD_ADDR: begin
          if (mem_ack) begin
            state      <= RD_DATA;
            cnt        <= len_q;
            last_rd_dc <= (owner == DC);
          end
        end
        RD_DATA: begin
          if (mem_rvalid) begin
            if (cnt_zero)
              state <= IDLE;
            else
              cnt <= cnt - LEN_W'(1);
          end
        end
        WR_ADDR: begin
          if (mem_ack) begin
            state <= WR_DATA;
            cnt   <= len_q;
          end
        end
        WR_DATA: begin
          if (mem_wready) begin
            if (cnt_zero)
              state <= WR_RESP;
            else
              cnt <= cnt - LEN_W'(1);
          end
        end
        WR_RESP: begin
          if (mem_bvalid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Winner's address/length are captured on the arbitration edge and held for the burst.
  always_ff @(posedge clk) begin
    if (arb_fire) begin
      if (wr_req) begin
        addr_q <= wr_addr;
        len_q  <= wr_len;
      end else if (rd_pick_dc) begin
        addr_q <= rd_addr[1];
        len_q  <= rd_len[1];
      end else begin
        addr_q <= rd_addr[0];
        len_q  <= rd_len[0];
      end
    end
  end

  always_comb begin
    mem_req    = in_addr;
    mem_we     = (state == WR_ADDR);
    mem_addr   = in_addr ? addr_q : '0;
    mem_len    = in_addr ? len_q : '0;

    rd_gnt     = (!rst && state == RD_ADDR && mem_ack) ? owner_oh : 2'b00;
    wr_gnt     = !rst && (state == WR_ADDR) && mem_ack;

    rd_valid   = (!rst && state == RD_DATA && mem_rvalid) ? owner_oh : 2'b00;
    rd_data    = (state == RD_DATA) ? mem_rdata : '0;
    rd_last    = !rst && (state == RD_DATA) && mem_rvalid && cnt_zero;

    mem_wvalid = (state == WR_DATA);
    mem_wdata  = (state == WR_DATA) ? wr_data : '0;
    mem_wlast  = (state == WR_DATA) && cnt_zero;
    wr_ready   = !rst && (state == WR_DATA) && mem_wready;

    wr_done    = !rst && (state == WR_RESP) && mem_bvalid;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration order, burst beats, boundary lengths, reset.
module tb_mem_bus_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        rd_req;
  logic [1:0][31:0]  rd_addr;
  logic [1:0][3:0]   rd_len;
  logic [1:0]        rd_gnt;
  logic [1:0]        rd_valid;
  logic [31:0]       rd_data;
  logic              rd_last;
  logic              wr_req;
  logic [31:0]       wr_addr;
  logic [3:0]        wr_len;
  logic              wr_gnt;
  logic [31:0]       wr_data;
  logic              wr_ready;
  logic              wr_done;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [3:0]        mem_len;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              mem_wvalid;
  logic [31:0]       mem_wdata;
  logic              mem_wlast;
  logic              mem_wready;
  logic              mem_bvalid;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
    .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast),
    .mem_wready(mem_wready), .mem_bvalid(mem_bvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Entered just after the edge that moved the arbiter into RD_ADDR.
  task automatic run_read(input int own, input logic [31:0] a, input logic [3:0] len,
                          input int ack_dly, input string tag);
    logic [1:0]  oh;
    logic [31:0] beat;
    oh = (own == 0) ? 2'b01 : 2'b10;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== a || mem_len !== len) begin
      errors++;
      $display("FAIL %s addr_phase: req=%b we=%b addr=%h len=%0d, expected 1 0 %h %0d",
               tag, mem_req, mem_we, mem_addr, mem_len, a, len);
    end
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      mem_ack = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hdead_beef;
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== a || mem_len !== len || rd_gnt !== 2'b00 ||
          rd_valid !== 2'b00) begin
        errors++;
        $display("FAIL %s addr_hold[%0d]: req=%b addr=%h len=%0d gnt=%b valid=%b, expected 1 %h %0d 00 00",
                 tag, i, mem_req, mem_addr, mem_len, rd_gnt, rd_valid, a, len);
      end
    end
    tick();
    mem_rvalid = 1'b0;
    mem_ack = 1'b1;
    #1;
    checks++;
    if (rd_gnt !== oh || wr_gnt !== 1'b0 || mem_addr !== a) begin
      errors++;
      $display("FAIL %s grant: rd_gnt=%b wr_gnt=%b addr=%h, expected %b 0 %h",
               tag, rd_gnt, wr_gnt, mem_addr, oh, a);
    end
    tick();
    mem_ack = 1'b0;
    rd_req[own] = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == 1) begin
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 2'b00 || rd_last !== 1'b0 || mem_req !== 1'b0 || rd_gnt !== 2'b00) begin
          errors++;
          $display("FAIL %s gap: valid=%b last=%b req=%b gnt=%b, expected 00 0 0 00",
                   tag, rd_valid, rd_last, mem_req, rd_gnt);
        end
        tick();
      end
      beat = a ^ b;
      mem_rvalid = 1'b1;
      mem_rdata = beat;
      #1;
      checks++;
      if (rd_valid !== oh || rd_data !== beat || rd_last !== (b == int'(len))) begin
        errors++;
        $display("FAIL %s beat[%0d]: valid=%b data=%h last=%b, expected %b %h %b",
                 tag, b, rd_valid, rd_data, rd_last, oh, beat, (b == int'(len)));
      end
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata = 32'h5555_aaaa;
    #1;
    checks++;
    if (mem_req !== 1'b0 || rd_valid !== 2'b00 || rd_last !== 1'b0 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL %s idle_after: req=%b valid=%b last=%b data=%h, expected 0 00 0 0",
               tag, mem_req, rd_valid, rd_last, rd_data);
    end
    mem_rvalid = 1'b0;
  endtask

  // Entered just after the edge that moved the arbiter into WR_ADDR.
  task automatic run_write(input logic [31:0] a, input logic [3:0] len, input string tag);
    logic [31:0] beat;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a || mem_len !== len) begin
      errors++;
      $display("FAIL %s addr_phase: req=%b we=%b addr=%h len=%0d, expected 1 1 %h %0d",
               tag, mem_req, mem_we, mem_addr, mem_len, a, len);
    end
    tick();
    mem_ack = 1'b1;
    #1;
    checks++;
    if (wr_gnt !== 1'b1 || rd_gnt !== 2'b00) begin
      errors++;
      $display("FAIL %s grant: wr_gnt=%b rd_gnt=%b, expected 1 00", tag, wr_gnt, rd_gnt);
    end
    tick();
    mem_ack = 1'b0;
    wr_req = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      beat = a + b;
      wr_data = beat;
      if (b == 0) begin
        mem_wready = 1'b0;
        #1;
        checks++;
        if (mem_wvalid !== 1'b1 || wr_ready !== 1'b0 || mem_wdata !== beat ||
            mem_we !== 1'b0 || mem_req !== 1'b0) begin
          errors++;
          $display("FAIL %s stall: wvalid=%b ready=%b wdata=%h we=%b req=%b, expected 1 0 %h 0 0",
                   tag, mem_wvalid, wr_ready, mem_wdata, mem_we, mem_req, beat);
        end
        tick();
      end
      mem_wready = 1'b1;
      #1;
      checks++;
      if (mem_wvalid !== 1'b1 || wr_ready !== 1'b1 || mem_wdata !== beat ||
          mem_wlast !== (b == int'(len))) begin
        errors++;
        $display("FAIL %s beat[%0d]: wvalid=%b ready=%b wdata=%h wlast=%b, expected 1 1 %h %b",
                 tag, b, mem_wvalid, wr_ready, mem_wdata, mem_wlast, beat, (b == int'(len)));
      end
      tick();
    end
    mem_wready = 1'b0;
    wr_data = 32'h0;
    #1;
    checks++;
    if (mem_wvalid !== 1'b0 || wr_done !== 1'b0 || mem_wlast !== 1'b0) begin
      errors++;
      $display("FAIL %s resp_wait: wvalid=%b done=%b wlast=%b, expected 0 0 0",
               tag, mem_wvalid, wr_done, mem_wlast);
    end
    tick();
    mem_bvalid = 1'b1;
    #1;
    checks++;
    if (wr_done !== 1'b1) begin
      errors++;
      $display("FAIL %s done: wr_done=%b, expected 1", tag, wr_done);
    end
    tick();
    mem_bvalid = 1'b0;
    #1;
    checks++;
    if (wr_done !== 1'b0 || mem_req !== 1'b0 || mem_wvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: done=%b req=%b wvalid=%b, expected 0 0 0",
               tag, wr_done, mem_req, mem_wvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_req = 2'b11; wr_req = 1'b1;
    rd_addr[0] = 32'h0; rd_addr[1] = 32'h0; rd_len[0] = 4'd0; rd_len[1] = 4'd0;
    wr_addr = 32'h0; wr_len = 4'd0; wr_data = 32'h0;
    mem_ack = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    mem_wready = 1'b1; mem_bvalid = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wvalid !== 1'b0 || rd_gnt !== 2'b00 ||
        wr_gnt !== 1'b0 || wr_done !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: req=%b we=%b wvalid=%b rd_gnt=%b wr_gnt=%b done=%b addr=%h, expected all 0",
               mem_req, mem_we, mem_wvalid, rd_gnt, wr_gnt, wr_done, mem_addr);
    end
    rst = 1'b0;
    rd_req = 2'b00; wr_req = 1'b0;
    mem_ack = 1'b0; mem_wready = 1'b0; mem_bvalid = 1'b0;
    tick();
    #1;
    checks++;
    if (mem_req !== 1'b0 || rd_valid !== 2'b00 || rd_last !== 1'b0 || wr_ready !== 1'b0 ||
        mem_wlast !== 1'b0 || mem_len !== 4'd0 || rd_data !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_idle: req=%b valid=%b last=%b ready=%b wlast=%b len=%0d, expected all 0",
               mem_req, rd_valid, rd_last, wr_ready, mem_wlast, mem_len);
    end
  endtask

  task automatic test_rr_tie();
    rd_addr[0] = 32'h0000_1000; rd_len[0] = 4'd1;
    rd_addr[1] = 32'h0000_2000; rd_len[1] = 4'd1;
    rd_req = 2'b11;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL tie_latency: mem_req=%b in arbitration cycle, expected 0", mem_req);
    end
    tick();
    run_read(0, 32'h0000_1000, 4'd1, 0, "tie1_ic");
    tick();
    run_read(1, 32'h0000_2000, 4'd1, 0, "tie1_dc");
    rd_req = 2'b11;
    tick();
    run_read(0, 32'h0000_1000, 4'd1, 0, "tie2_ic");
    rd_req = 2'b00;
    tick();
  endtask

  task automatic test_wr_priority();
    rd_addr[1] = 32'h0000_2200; rd_len[1] = 4'd2;
    wr_addr = 32'h0000_3000; wr_len = 4'd3;
    rd_req = 2'b10; wr_req = 1'b1;
    tick();
    run_write(32'h0000_3000, 4'd3, "wr_first");
    tick();
    run_read(1, 32'h0000_2200, 4'd2, 0, "dc_after_wr");
    tick();
  endtask

  task automatic test_delayed_ack();
    rd_addr[0] = 32'h0000_7700; rd_len[0] = 4'd7;
    rd_req = 2'b01;
    tick();
    rd_req = 2'b00;
    run_read(0, 32'h0000_7700, 4'd7, 3, "ic_delayed_flush");
    tick();
  endtask

  task automatic test_len_edges();
    rd_addr[0] = 32'h0000_0040; rd_len[0] = 4'd0;
    rd_req = 2'b01;
    tick();
    run_read(0, 32'h0000_0040, 4'd0, 1, "rd_len0");
    wr_addr = 32'h0000_0080; wr_len = 4'd0;
    wr_req = 1'b1;
    tick();
    run_write(32'h0000_0080, 4'd0, "wr_len0");
    rd_addr[1] = 32'h0000_f000; rd_len[1] = 4'd15;
    rd_req = 2'b10;
    tick();
    run_read(1, 32'h0000_f000, 4'd15, 0, "rd_len15");
    tick();
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_addr[0] = 32'h0000_4000; rd_len[0] = 4'd3;
    rd_addr[1] = 32'h0000_5000; rd_len[1] = 4'd1;
    rd_req = 2'b01;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    rd_req = 2'b11;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_0000;
    #1;
    checks++;
    if (rd_valid !== 2'b01 || rd_last !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_beat0: valid=%b last=%b, expected 01 0", rd_valid, rd_last);
    end
    tick();
    rst = 1'b1;
    mem_rdata = 32'h1111_0001;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 2'b00 || rd_last !== 1'b0 || rd_data !== 32'h0 || mem_req !== 1'b0 ||
        rd_gnt !== 2'b00 || mem_wvalid !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_cleared: valid=%b last=%b data=%h req=%b gnt=%b wvalid=%b addr=%h, expected all 0",
               rd_valid, rd_last, rd_data, mem_req, rd_gnt, mem_wvalid, mem_addr);
    end
    tick();
    mem_rvalid = 1'b0;
    run_read(0, 32'h0000_4000, 4'd3, 0, "rstmid_ic_again");
    tick();
    run_read(1, 32'h0000_5000, 4'd1, 0, "rstmid_dc_next");
    rd_req = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_rr_tie();
    test_wr_priority();
    test_delayed_ack();
    test_len_edges();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter
Interface
REQ-001 SHALL have parameter LEN_W, default 4, burst-length field width; a burst is len+1 beats, 1..2^LEN_W.
REQ-002 SHALL have clk  in  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have rd_req  in  2  read requests; bit0 = icache refill, bit1 = dcache refill/uncached read.
REQ-005 SHALL have rd_addr  in  2 x phys_t  per-requester read start address, stable while rd_req high.
REQ-006 SHALL have rd_len  in  2 x LEN_W  per-requester beats-1, stable while rd_req high.
REQ-007 SHALL have rd_gnt  out  2  one-cycle pulse: request accepted by memory; requester drops or renews rd_req next cycle.
REQ-008 SHALL have rd_valid  out  2  read beat valid, one-hot to the burst owner.
REQ-009 SHALL have rd_data  out  32  read beat data, shared by both read requesters.
REQ-010 SHALL have rd_last  out  1  final beat of the current read burst.
REQ-011 SHALL have wr_req / wr_addr / wr_len  in  1 / phys_t / LEN_W  dcache writeback request, stable while wr_req high.
REQ-012 SHALL have wr_gnt  out  1  one-cycle pulse: write address accepted.
REQ-013 SHALL have wr_data  in  32  current write beat, valid whenever in write-data phase.
REQ-014 SHALL have wr_ready  out  1  current write beat consumed; writer advances to next beat.
REQ-015 SHALL have wr_done  out  1  one-cycle pulse on memory write response.
REQ-016 SHALL have mem_req / mem_we / mem_addr / mem_len  out  1 / 1 / phys_t / LEN_W  memory address-phase request.
REQ-017 SHALL have mem_ack  in  1  memory accepted address phase.
REQ-018 SHALL have mem_rvalid / mem_rdata  in  1 / 32  memory read beat.
REQ-019 SHALL have mem_wvalid / mem_wdata / mem_wlast  out  1 / 32 / 1  memory write beat; mem_wready in 1 accepts it.
REQ-020 SHALL have mem_bvalid  in  1  memory write response.
Function
REQ-021 SHALL implement FSM IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP; one transaction outstanding at a time.
REQ-022 SHALL arbitrate only in IDLE: wr_req beats any read (dcache eviction precedes its refill); between reads, round-robin on a last_rd bit (reset = DC, so IC wins first tie).
REQ-023 SHALL register the winner's addr/len/owner on the arbitration edge; mem_req high from the next cycle (1-cycle request-to-mem_req latency).
REQ-024 SHALL hold mem_req and address fields constant until mem_ack; on mem_ack pulse rd_gnt[owner] or wr_gnt and move to RD_DATA or WR_DATA.
REQ-025 SHALL count beats with a LEN_W-bit down-counter loaded with len; rd_valid[owner] = mem_rvalid in RD_DATA; rd_data = mem_rdata combinationally.
REQ-026 SHALL assert rd_last on the beat where counter = 0 and return to IDLE the following cycle; mem_rvalid outside RD_DATA is ignored.
REQ-027 SHALL drive mem_wvalid = 1 in WR_DATA, mem_wdata = wr_data, wr_ready = mem_wready, mem_wlast when counter = 0; on last accepted beat enter WR_RESP.
REQ-028 SHALL pulse wr_done on mem_bvalid in WR_RESP and return to IDLE; IDLE lasts at least one cycle between transactions.
REQ-029 SHALL update last_rd only when a read is granted (on mem_ack).
REQ-030 SHALL not abandon a granted burst; a requester withdrawing rd_req/wr_req after arbitration (e.g. pipeline flush) does not affect the transaction, and its beats are still delivered.
REQ-031 SHALL drive mem_we = 1 only in WR_ADDR; all mem_* outputs 0 in IDLE.
REQ-032 SHALL support len = 0 (single beat) with rd_last/mem_wlast on the first beat, and len = 2^LEN_W-1 without counter wrap.
Reset
REQ-033 SHALL on rst force IDLE, last_rd = DC, counter = 0, and every output to 0, from the next cycle, including mid-burst (in-flight transfer dropped; memory side is reset together).
REQ-034 SHALL ignore all inputs in the cycle rst is high.
Structure
REQ-035 SHALL place arb_state_t, arb_owner_t (IC, DC, WB) and mem_len_t in the shared cpu_defs package; phys_t comes from that package.
REQ-036 SHALL be one flat module; no sub-module is required.
Verification
REQ-037 SHALL cover: rd_req=2'b11 same cycle after reset -> IC granted first (rd_gnt=01), then DC; next tie -> IC again.
REQ-038 SHALL cover: wr_req and rd_req[1] together, wr_len=3 -> WR burst of 4 beats, mem_wlast on 4th, wr_done, then DC read.
REQ-039 SHALL cover: IC read len=7, mem_ack delayed 3 cycles -> mem_req/mem_addr stable 4 cycles, 8 rd_valid[0] beats, rd_last on 8th.
REQ-040 SHALL cover: len=0 read and write -> single beat with rd_last / mem_wlast, return to IDLE after one beat (plus response for write).
REQ-041 SHALL cover: rst asserted during beat 2 of a 4-beat read -> all outputs 0 next cycle, FSM IDLE, pending rd_req re-arbitrated with IC first.
